pong_engine: RTL
================

# pong_engine

Sequential game core that produces the ball position, both paddle positions and both scores consumed by the combinational `led` matrix renderer. Runs a serve/play/game-over state machine, moves the ball and paddles once per game tick, resolves wall bounces, paddle hits and misses, and keeps score to a fixed win value. All outputs are registered and connect straight to `led` ports `bx`, `by`, `p1y`, `p2y`, `sc1`, `sc2`.

## Interface
- `TICK_DIV`, 1000000: clock cycles per game tick.
- `SERVE_TICKS`, 16: ticks held in SERVE before play.
- `PADDLE_H`, 8: paddle height in rows.
- `WIN_SCORE`, 7: score that ends the game (must be ≤ 7).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin/restart the game; sampled each clock, honoured only in IDLE or OVER.
- `p1_up`, `p1_dn`, `p2_up`, `p2_dn` in 1 each: paddle controls, level-sampled on ticks.
- `bx`, `by` out 6: ball column and row, 0..63.
- `p1y`, `p2y` out 6: paddle top row, 0..64-PADDLE_H.
- `sc1`, `sc2` out 3: player scores.
- `serving` out 1: high while in SERVE.
- `game_over` out 1: high while in OVER.
- `tick` out 1: one-cycle game-tick pulse.

## Operation
- Tick counter runs 0..TICK_DIV-1 from reset, regardless of state. `tick`=1 on the cycle it equals TICK_DIV-1, then it wraps to 0. Only `rst` clears it.
- Geometry: P1 paddle at column 1, P2 at column 62. A paddle covers rows p..p+PADDLE_H-1.
- Hidden direction bits: dx, dy, each ±1.
- States:
  - IDLE: ball (31,31), paddles 28, scores 0. `start` → SERVE next cycle with dx=+1, dy=+1.
  - SERVE: ball held at (31,31). After SERVE_TICKS ticks → PLAY.
  - PLAY: on each tick, update ball and paddles as below.
  - OVER: all outputs frozen. `start` → SERVE with scores 0, ball (31,31), dx=+1, dy=+1, paddles unchanged.
- `start` in SERVE or PLAY is ignored.
- Paddle update (tick, SERVE or PLAY):
  - up only: decrement if >0.
  - dn only: increment if <64-PADDLE_H.
  - both or neither: hold.
- Ball update (tick, PLAY). All checks use pre-tick bx, by, dx, dy and pre-tick paddle values. Priority order:
  1. Point: dx=-1 and bx==0 gives P2 a point; dx=+1 and bx==63 gives P1 a point. Scorer's score +1. If the new score == WIN_SCORE → OVER with the ball left in place. Otherwise → SERVE, ball (31,31), dx points toward the conceding player (P1 conceded → dx=-1), dy unchanged.
  2. Paddle hit: dx=-1, bx==2, by in P1 span → dx=+1, next bx=3. dx=+1, bx==61, by in P2 span → dx=-1, next bx=60. Otherwise next bx=bx+dx.
  3. Vertical: dy=-1 at by==0 → dy=+1, next by=1. dy=+1 at by==63 → dy=-1, next by=62. Otherwise next by=by+dy.
  - Horizontal and vertical updates apply in the same tick.
- A missed ball passes through columns 1 and 0 (or 62 and 63) before scoring.
- Score arithmetic is 3-bit unsigned and never exceeds WIN_SCORE.

## Timing
- Reset values: bx=31, by=31, p1y=28, p2y=28, sc1=0, sc2=0, serving=0, game_over=0, tick=0, state IDLE, dx=+1, dy=+1, tick counter 0.
- `rst` asserted mid-game returns immediately to these values; the game restarts only on a new `start`.
- State transitions and output updates take effect on the clock edge where the condition (tick or `start`) is sampled. Outputs are visible the following cycle.
- SERVE lasts exactly SERVE_TICKS ticks. The SERVE→PLAY edge moves nothing. The first ball move happens on the next tick.
- Outputs change at most once per tick while in SERVE or PLAY.

## Test plan
All scenarios use TICK_DIV=4, SERVE_TICKS=2, PADDLE_H=8, WIN_SCORE=7.
- Reset: assert `rst` → all outputs at the listed reset values; `tick` pulses every 4 cycles after release.
- Start/serve: pulse `start` → `serving`=1 next cycle. After 2 ticks, state is PLAY with ball at (31,31). First PLAY tick → (32,32).
- Hit and wall bounce: hold `p2_dn` from `start`. p2y clamps at 56. On play tick 30 the ball is at (61,61). Tick 31 → (60,62) moving left. Tick 32 → (59,63). Tick 33 → (58,62) moving up.
- Miss and score: no paddle input, p2y=28. Ticks 31, 32 → (62,62), (63,63). Tick 33 → sc1=1, ball (31,31), `serving`=1, then ball moves with dx=+1.
- Paddle rules: p1_up and p1_dn held together → p1y holds at 28. p1_up alone for 40 ticks → p1y=0 and stays 0. `start` pulsed during PLAY → no effect.
- Game over and restart: force misses until sc1=7 → `game_over`=1 and outputs frozen across ticks. `start` → sc1=sc2=0, `serving`=1. `rst` asserted mid-PLAY → reset values next cycle.

Source files
------------

// File: rtl/pong_engine.sv
// Pong game core: serve/play/over FSM, once-per-tick ball and paddle motion,
// wall bounces, paddle hits, misses and scoring. All outputs are registered.
module pong_engine #(
    parameter int TICK_DIV    = 1000000,
    parameter int SERVE_TICKS = 16,
    parameter int PADDLE_H    = 8,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic [2:0] sc1,
    output logic [2:0] sc2,
    output logic       serving,
    output logic       game_over,
    output logic       tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
    localparam logic [5:0]    P_MAX      = 6'(64 - PADDLE_H);
    localparam logic [6:0]    SPAN       = 7'(PADDLE_H - 1);
    localparam logic [5:0]    CENTER     = 6'd31;
    localparam logic [5:0]    P_HOME     = 6'd28;
    localparam logic [2:0]    WIN        = 3'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] serve_cnt, serve_cnt_nxt;
    // Direction bits: 1 means +1 (right / down), 0 means -1.
    logic          dx, dy, dx_nxt, dy_nxt;
    logic [5:0]    bx_nxt, by_nxt, p1y_nxt, p2y_nxt;
    logic [2:0]    sc1_nxt, sc2_nxt;

    function automatic logic [5:0] move_paddle(input logic [5:0] p, input logic up,
                                               input logic dn);
        logic [5:0] r;
        r = p;
        if (up && !dn && p != 6'd0)
            r = p - 6'd1;
        else if (dn && !up && p < P_MAX)
            r = p + 6'd1;
        return r;
    endfunction

    function automatic logic in_span(input logic [5:0] row, input logic [5:0] top);
        return ({1'b0, row} >= {1'b0, top}) && ({1'b0, row} <= ({1'b0, top} + SPAN));
    endfunction

    assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            tick      <= 1'b0;
            state     <= IDLE;
            serve_cnt <= '0;
            bx        <= CENTER;
            by        <= CENTER;
            p1y       <= P_HOME;
            p2y       <= P_HOME;
            sc1       <= 3'd0;
            sc2       <= 3'd0;
            dx        <= 1'b1;
            dy        <= 1'b1;
            serving   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            tick      <= (cnt_nxt == CNT_LAST);
            state     <= state_nxt;
            serve_cnt <= serve_cnt_nxt;
            bx        <= bx_nxt;
            by        <= by_nxt;
            p1y       <= p1y_nxt;
            p2y       <= p2y_nxt;
            sc1       <= sc1_nxt;
            sc2       <= sc2_nxt;
            dx        <= dx_nxt;
            dy        <= dy_nxt;
            serving   <= (state_nxt == SERVE);
            game_over <= (state_nxt == OVER);
        end
    end

    always_comb begin
        state_nxt     = state;
        serve_cnt_nxt = serve_cnt;
        bx_nxt        = bx;
        by_nxt        = by;
        p1y_nxt       = p1y;
        p2y_nxt       = p2y;
        sc1_nxt       = sc1;
        sc2_nxt       = sc2;
        dx_nxt        = dx;
        dy_nxt        = dy;

        case (state)
            IDLE, OVER: begin
                // A restart from OVER keeps the paddles where they were.
                if (start) begin
                    state_nxt     = SERVE;
                    serve_cnt_nxt = '0;
                    bx_nxt        = CENTER;
                    by_nxt        = CENTER;
                    sc1_nxt       = 3'd0;
                    sc2_nxt       = 3'd0;
                    dx_nxt        = 1'b1;
                    dy_nxt        = 1'b1;
                end
            end
            SERVE: begin
                if (tick) begin
                    p1y_nxt = move_paddle(p1y, p1_up, p1_dn);
                    p2y_nxt = move_paddle(p2y, p2_up, p2_dn);
                    if (serve_cnt == SERVE_LAST) begin
                        state_nxt     = PLAY;
                        serve_cnt_nxt = '0;
                    end else begin
                        serve_cnt_nxt = serve_cnt + SW'(1);
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    p1y_nxt = move_paddle(p1y, p1_up, p1_dn);
                    p2y_nxt = move_paddle(p2y, p2_up, p2_dn);
                    if (!dx && bx == 6'd0) begin
                        sc2_nxt = sc2 + 3'd1;
                        if (sc2_nxt == WIN) begin
                            state_nxt = OVER;
                        end else begin
                            state_nxt     = SERVE;
                            serve_cnt_nxt = '0;
                            bx_nxt        = CENTER;
                            by_nxt        = CENTER;
                            dx_nxt        = 1'b0;
                        end
                    end else if (dx && bx == 6'd63) begin
                        sc1_nxt = sc1 + 3'd1;
                        if (sc1_nxt == WIN) begin
                            state_nxt = OVER;
                        end else begin
                            state_nxt     = SERVE;
                            serve_cnt_nxt = '0;
                            bx_nxt        = CENTER;
                            by_nxt        = CENTER;
                            dx_nxt        = 1'b1;
                        end
                    end else begin
                        if (!dx && bx == 6'd2 && in_span(by, p1y)) begin
                            dx_nxt = 1'b1;
                            bx_nxt = 6'd3;
                        end else if (dx && bx == 6'd61 && in_span(by, p2y)) begin
                            dx_nxt = 1'b0;
                            bx_nxt = 6'd60;
                        end else begin
                            bx_nxt = dx ? bx + 6'd1 : bx - 6'd1;
                        end

                        if (!dy && by == 6'd0) begin
                            dy_nxt = 1'b1;
                            by_nxt = 6'd1;
                        end else if (dy && by == 6'd63) begin
                            dy_nxt = 1'b0;
                            by_nxt = 6'd62;
                        end else begin
                            by_nxt = dy ? by + 6'd1 : by - 6'd1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
